user_proj_timer_bank: RTL and testbench

- Parametrised successor to the single-counter user project. Provides NUM_CH independent WIDTH-bit counter/timer channels behind the Wishbone slave port.
- Each channel has a compare register, a periodic or one-shot mode, a sticky match flag, an IRQ contribution and a toggling GPIO output.
- Instantiated inside user_project_wrapper in place of the example project.
- Also exposes a logic-analyzer freeze control and an LA observation bus.

---
 rtl/user_proj_timer_pkg.sv | 28 ++
 rtl/timer_channel.sv | 100 ++++++++++
 rtl/user_proj_timer_bank.sv | 115 +++++++++++
 tb/tb_user_proj_timer_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/user_proj_timer_pkg.sv
// rtl/user_proj_timer_pkg.sv - register map, control layout and shared types for the timer bank
package user_proj_timer_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQ_EN  = 2;

    typedef struct packed {
        logic irq_en;
        logic oneshot;
        logic en;
    } ctrl_t;

    typedef enum logic {
        WB_IDLE,
        WB_ACK
    } wb_state_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one counter/compare channel with byte-masked write port and read mux
module timer_channel
    import user_proj_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frozen,
    input  logic             wr_en,
    input  logic [1:0]       wr_reg,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_sel,
    input  logic [1:0]       rd_reg,
    output logic [31:0]      rd_data,
    output logic             toggle,
    output logic             irq_req,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_nx, compare_q, compare_nx, wmask, wdata;
    logic [31:0]      mask32;
    ctrl_t            ctrl_q, ctrl_nx;
    logic             flag_q, flag_nx, toggle_q, toggle_nx, match;

    assign mask32 = byte_mask(wr_sel);
    assign wmask  = mask32[WIDTH-1:0];
    assign wdata  = wr_data[WIDTH-1:0];
    assign match  = ctrl_q.en & ~frozen & (count_q == compare_q);

    // Counter update first, then bus writes overlay it so written bytes win.
    always_comb begin
        count_nx   = count_q;
        compare_nx = compare_q;
        ctrl_nx    = ctrl_q;
        flag_nx    = flag_q;
        toggle_nx  = toggle_q;
        if (ctrl_q.en && !frozen) begin
            if (match) begin
                flag_nx   = 1'b1;
                toggle_nx = ~toggle_q;
                if (ctrl_q.oneshot) ctrl_nx.en = 1'b0;
                else                count_nx   = '0;
            end else begin
                count_nx = count_q + 1'b1;
            end
        end
        if (wr_en) begin
            case (wr_reg)
                REG_CTRL: begin
                    if (wr_sel[0]) begin
                        ctrl_nx.en      = wr_data[CTRL_EN];
                        ctrl_nx.oneshot = wr_data[CTRL_ONESHOT];
                        ctrl_nx.irq_en  = wr_data[CTRL_IRQ_EN];
                    end
                end
                REG_COUNT:   count_nx   = (count_nx & ~wmask) | (wdata & wmask);
                REG_COMPARE: compare_nx = (compare_q & ~wmask) | (wdata & wmask);
                REG_STATUS:  if (wr_sel[0] && wr_data[0] && !match) flag_nx = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            ctrl_q    <= '0;
            flag_q    <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            count_q   <= count_nx;
            compare_q <= compare_nx;
            ctrl_q    <= ctrl_nx;
            flag_q    <= flag_nx;
            toggle_q  <= toggle_nx;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_reg)
            REG_CTRL: begin
                rd_data[CTRL_EN]      = ctrl_q.en;
                rd_data[CTRL_ONESHOT] = ctrl_q.oneshot;
                rd_data[CTRL_IRQ_EN]  = ctrl_q.irq_en;
            end
            REG_COUNT:   rd_data[WIDTH-1:0] = count_q;
            REG_COMPARE: rd_data[WIDTH-1:0] = compare_q;
            REG_STATUS:  rd_data[0]         = flag_q;
            default: ;
        endcase
    end

    assign toggle  = toggle_q;
    assign irq_req = flag_q & ctrl_q.irq_en;
    assign count   = count_q;

endmodule

// File: rtl/user_proj_timer_bank.sv
// rtl/user_proj_timer_bank.sv - Wishbone-mapped bank of NUM_CH timer channels with IRQ, GPIO and LA hooks
module user_proj_timer_bank
    import user_proj_timer_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          WIDTH    = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          IO_LSB   = 8,
    parameter int          IO_PADS  = 38
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic [127:0]       la_data_in,
    input  logic [127:0]       la_oenb,
    output logic [127:0]       la_data_out,
    output logic [IO_PADS-1:0] io_out,
    output logic [IO_PADS-1:0] io_oeb,
    output logic [2:0]         irq
);

    wb_state_t                        state_q;
    logic                             hit, wr_go, frozen, irq_q;
    logic [3:0]                       ch_idx;
    logic [1:0]                       reg_idx;
    logic [31:0]                      rd_mux;
    logic [NUM_CH-1:0][31:0]          ch_rd;
    logic [NUM_CH-1:0][WIDTH-1:0]     ch_count;
    logic [NUM_CH-1:0]                ch_toggle, ch_irq;

    assign ch_idx  = wbs_adr_i[7:4];
    assign reg_idx = wbs_adr_i[3:2];
    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign wr_go   = hit & wbs_we_i & (state_q == WB_IDLE);
    assign frozen  = ~la_oenb[0] & la_data_in[0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (wb_clk_i),
            .rst_n   (wb_rst_ni),
            .frozen  (frozen),
            .wr_en   (wr_go && (ch_idx == 4'(i))),
            .wr_reg  (reg_idx),
            .wr_data (wbs_dat_i),
            .wr_sel  (wbs_sel_i),
            .rd_reg  (reg_idx),
            .rd_data (ch_rd[i]),
            .toggle  (ch_toggle[i]),
            .irq_req (ch_irq[i]),
            .count   (ch_count[i])
        );
    end

    // Unpopulated channel slots fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == 4'(i)) rd_mux = ch_rd[i];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= WB_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            case (state_q)
                WB_IDLE: begin
                    if (hit) begin
                        state_q   <= WB_ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= wbs_we_i ? 32'd0 : rd_mux;
                    end else begin
                        wbs_ack_o <= 1'b0;
                        wbs_dat_o <= '0;
                    end
                end
                default: begin
                    state_q   <= WB_IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) irq_q <= 1'b0;
        else            irq_q <= |ch_irq;
    end

    always_comb begin
        io_out = '0;
        io_oeb = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            io_out[IO_LSB+i] = ch_toggle[i];
            io_oeb[IO_LSB+i] = 1'b0;
        end
    end

    assign irq         = {2'b00, irq_q};
    assign la_data_out = {96'd0, 32'(ch_count[0])};

    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_adr_i[1:0], la_data_in[127:1], la_oenb[127:1], ch_count};

endmodule

// File: tb/tb_user_proj_timer_bank.sv
// tb/tb_user_proj_timer_bank.sv - directed table-driven bench for user_proj_timer_bank
module tb_user_proj_timer_bank;

    localparam int          NUM_CH  = 4;
    localparam int          WIDTH   = 32;
    localparam int          IO_LSB  = 8;
    localparam int          IO_PADS = 38;
    localparam logic [31:0] A       = 32'h3000_0000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cyc, stb, we;
    logic [3:0]         sel;
    logic [31:0]        adr, wdat;
    logic               ack;
    logic [31:0]        rdat_o;
    logic [127:0]       la_in, la_oenb, la_out;
    logic [IO_PADS-1:0] io_out, io_oeb;
    logic [2:0]         irq;

    user_proj_timer_bank #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .BASE_ADR(A), .IO_LSB(IO_LSB), .IO_PADS(IO_PADS)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
        .la_data_in(la_in), .la_oenb(la_oenb), .la_data_out(la_out),
        .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output bit acked);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0;
        rd = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) begin
                acked = 1'b1;
                rd = rdat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        bit          acked;
        wb_xfer(1'b1, a, d, s, rd, acked);
        check("wr_ack", 128'(acked), 128'd1);
    endtask

    task automatic wb_rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        bit          acked;
        wb_xfer(1'b0, a, 32'd0, 4'hF, rd, acked);
        check({name, "_ack"}, 128'(acked), 128'd1);
        check(name, 128'(rd), 128'(exp));
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          exp_ack;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0]        rd, v0;
        bit                 acked;
        int                 first_tog, second_tog, first_irq, ntog, acks, drift;
        logic               prev;
        logic [IO_PADS-1:0] exp_oeb;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; wdat = '0;
        la_in = '0; la_oenb = '1;
        exp_oeb = ~(38'(4'hF) << IO_LSB);

        repeat (3) @(negedge clk);
        check("rst_ack", 128'(ack), 128'd0);
        check("rst_dat", 128'(rdat_o), 128'd0);
        check("rst_la", la_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_io", 128'(io_out), 128'd0);
        check("idle_irq", 128'(irq), 128'd0);
        check("idle_ack", 128'(ack), 128'd0);
        check("io_oeb", 128'(io_oeb), 128'(exp_oeb));
        check("la_hi", 128'(la_out[127:32]), 128'd0);

        vecs[0]  = '{1'b0, A + 32'h00, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, A + 32'h04, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[2]  = '{1'b0, A + 32'h38, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, A + 32'h28, 32'hDEADBEEF,  4'hF, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, A + 32'h28, 32'h0,         4'hF, 1'b1, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, A + 32'h28, 32'hFFFFFFFF,  4'h1, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, A + 32'h28, 32'h0,         4'hF, 1'b1, 32'hDEADBEFF};
        vecs[7]  = '{1'b1, A + 32'h34, 32'h12345678,  4'hC, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, A + 32'h34, 32'h0,         4'hF, 1'b1, 32'h12340000};
        vecs[9]  = '{1'b1, A + 32'h30, 32'hFFFFFFFE,  4'hF, 1'b1, 32'h0};
        vecs[10] = '{1'b0, A + 32'h30, 32'h0,         4'hF, 1'b1, 32'h6};
        vecs[11] = '{1'b0, A + 32'hF0, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[12] = '{1'b1, A + 32'hF4, 32'hFFFFFFFF,  4'hF, 1'b1, 32'h0};
        vecs[13] = '{1'b0, A + 32'h100, 32'h0,        4'hF, 1'b0, 32'h0};
        vecs[14] = '{1'b0, A + 32'h1C, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[15] = '{1'b0, 32'h3100_0028, 32'h0,      4'hF, 1'b0, 32'h0};

        for (int i = 0; i < 16; i++) begin
            wb_xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, rd, acked);
            check($sformatf("vec%0d_ack", i), 128'(acked), 128'(vecs[i].exp_ack));
            if (!vecs[i].w && vecs[i].exp_ack)
                check($sformatf("vec%0d_dat", i), 128'(rd), 128'(vecs[i].exp_dat));
        end

        // Periodic channel 1, compare 4: match every 5 cycles, irq one cycle after flag.
        wb_wr(A + 32'h18, 32'd4, 4'hF);
        wb_wr(A + 32'h10, 32'h5, 4'hF);
        first_tog = -1; second_tog = -1; first_irq = -1;
        prev = io_out[IO_LSB+1];
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (io_out[IO_LSB+1] !== prev) begin
                if (first_tog < 0)       first_tog = k;
                else if (second_tog < 0) second_tog = k;
                prev = io_out[IO_LSB+1];
            end
            if (irq[0] && first_irq < 0) first_irq = k;
        end
        check("per_first_tog", 128'(first_tog), 128'd5);
        check("per_second_tog", 128'(second_tog), 128'd10);
        check("per_first_irq", 128'(first_irq), 128'd6);
        check("io_other_bits", 128'(io_out & ~(38'd2 << IO_LSB)), 128'd0);
        wb_wr(A + 32'h1C, 32'd1, 4'hF);
        @(negedge clk);
        check("w1c_irq_low", 128'(irq[0]), 128'd0);
        repeat (2) @(negedge clk);
        check("irq_after_rematch", 128'(irq[0]), 128'd1);
        wb_wr(A + 32'h10, 32'd0, 4'hF);

        // One-shot channel 0, compare 10.
        wb_wr(A + 32'h08, 32'd10, 4'hF);
        wb_wr(A + 32'h00, 32'h3, 4'hF);
        ntog = 0;
        prev = io_out[IO_LSB];
        repeat (30) begin
            @(negedge clk);
            if (io_out[IO_LSB] !== prev) begin
                ntog++;
                prev = io_out[IO_LSB];
            end
        end
        check("os_toggles", 128'(ntog), 128'd1);
        wb_rd_chk("os_count", A + 32'h04, 32'd10);
        wb_rd_chk("os_ctrl", A + 32'h00, 32'h2);
        check("os_la", 128'(la_out[31:0]), 128'd10);

        // COUNT write colliding with an increment on channel 0.
        wb_wr(A + 32'h08, 32'h1000, 4'hF);
        wb_wr(A + 32'h00, 32'h1, 4'hF);
        wb_wr(A + 32'h04, 32'h55, 4'hF);
        check("coll_count", 128'(la_out[31:0]), 128'h55);
        @(negedge clk);
        check("coll_resume", 128'(la_out[31:0]), 128'h56);

        // Channel 2 with compare 0 matches every cycle, so W1C always collides.
        wb_wr(A + 32'h28, 32'd0, 4'hF);
        wb_wr(A + 32'h20, 32'h1, 4'hF);
        wb_wr(A + 32'h2C, 32'd1, 4'hF);
        wb_rd_chk("w1c_coll_flag", A + 32'h2C, 32'd1);
        wb_wr(A + 32'h20, 32'd0, 4'hF);
        wb_wr(A + 32'h2C, 32'd1, 4'hF);
        wb_rd_chk("w1c_clear", A + 32'h2C, 32'd0);

        // Strobe held for 6 cycles yields three single-cycle acks.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A + 32'h04; sel = 4'hF;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("stb6_acks", 128'(acks), 128'd3);

        // Freeze via LA.
        @(negedge clk);
        la_oenb[0] = 1'b0; la_in[0] = 1'b1;
        @(negedge clk);
        v0 = la_out[31:0];
        drift = 0;
        repeat (20) begin
            @(negedge clk);
            if (la_out[31:0] !== v0) drift++;
        end
        check("freeze_drift", 128'(drift), 128'd0);
        wb_rd_chk("freeze_read", A + 32'h04, v0);
        la_oenb[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("freeze_gated", 128'(la_out[31:0] !== v0), 128'd1);
        la_in[0] = 1'b0;

        // Reset during an outstanding access.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A + 32'h04; sel = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        check("arst_la", la_out, 128'd0);
        check("arst_ack", 128'(ack), 128'd0);
        check("arst_io", 128'(io_out), 128'd0);
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("arst_no_ack", 128'(acks), 128'd0);
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        wb_rd_chk("post_rst_count0", A + 32'h04, 32'd0);
        wb_rd_chk("post_rst_cmp1", A + 32'h18, 32'd0);
        wb_rd_chk("post_rst_ctrl3", A + 32'h30, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
